// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin req/ack arbiter sharing one RAM port between fetch and load/store
module mem_port_arbiter #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int WaitCycles = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_req,
  input  logic [AddrWidth-1:0] i_addr,
  output logic                 i_ack,
  output logic [DataWidth-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [AddrWidth-1:0] d_addr,
  input  logic [DataWidth-1:0] d_wdata,
  output logic                 d_ack,
  output logic [DataWidth-1:0] d_rdata,
  output logic [AddrWidth-1:0] ram_addr,
  output logic                 ram_r,
  output logic                 ram_w,
  output logic [DataWidth-1:0] ram_wdata,
  input  logic [DataWidth-1:0] ram_rdata,
  output logic                 busy
);

  // Counter only has to hold WaitCycles-1; keep at least one bit.
  localparam int CntWidth = (WaitCycles > 1) ? $clog2(WaitCycles) : 1;
  localparam logic [CntWidth-1:0] CntLoad = CntWidth'(WaitCycles - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CntWidth-1:0]   cnt;
  logic                  grant_d;    // 1: current access belongs to D, 0: to I
  logic                  last_d;     // 1: D was granted last, 0: I was granted last
  logic                  lat_we;
  logic [AddrWidth-1:0]  lat_addr;
  logic [DataWidth-1:0]  lat_wdata;
  logic                  any_req;
  logic                  pick_d;

  // D wins if it is the only requester, or on a tie when I was served last.
  assign any_req = i_req | d_req;
  assign pick_d  = d_req & (~i_req | ~last_d);

  // The RAM bus always shows the latched request so it never floats between accesses.
  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: requests are only looked at in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: strobes only in ACCESS, ack only in RESP for the grantee.
  always_comb begin
    ram_r = 1'b0;
    ram_w = 1'b0;
    i_ack = 1'b0;
    d_ack = 1'b0;
    busy  = (state != IDLE);
    case (state)
      ACCESS: begin
        ram_r = ~lat_we;
        ram_w = lat_we;
      end
      RESP: begin
        i_ack = ~grant_d;
        d_ack = grant_d;
      end
      default: ;
    endcase
  end

  // Grant latch, wait counter, read-data capture and round-robin pointer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= '0;
      grant_d   <= 1'b0;
      last_d    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_d   <= pick_d;
            lat_addr  <= pick_d ? d_addr : i_addr;
            lat_we    <= pick_d & d_we;
            lat_wdata <= pick_d ? d_wdata : '0;
            cnt       <= CntLoad;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!lat_we) begin
            if (grant_d) d_rdata <= ram_rdata;
            else         i_rdata <= ram_rdata;
          end
        end
        RESP: begin
          last_d <= grant_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst1, rst3;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;

  logic        i_ack1, d_ack1, ram_r1, ram_w1, busy1;
  logic [31:0] i_rdata1, d_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
  logic        i_ack3, d_ack3, ram_r3, ram_w3, busy3;
  logic [31:0] i_rdata3, d_rdata3, ram_addr3, ram_wdata3, ram_rdata3;

  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DataWidth(32), .AddrWidth(32), .WaitCycles(1)) u1 (
    .CLK(clk), .RST(rst1),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack1), .i_rdata(i_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack1), .d_rdata(d_rdata1),
    .ram_addr(ram_addr1), .ram_r(ram_r1), .ram_w(ram_w1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1), .busy(busy1)
  );

  mem_port_arbiter #(.DataWidth(32), .AddrWidth(32), .WaitCycles(3)) u3 (
    .CLK(clk), .RST(rst3),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack3), .i_rdata(i_rdata3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .ram_addr(ram_addr3), .ram_r(ram_r3), .ram_w(ram_w3),
    .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3), .busy(busy3)
  );

  // Simple word RAMs decoding Addr[9:2]
  assign ram_rdata1 = mem1[ram_addr1[9:2]];
  assign ram_rdata3 = mem3[ram_addr3[9:2]];
  always @(posedge clk) if (ram_w1) mem1[ram_addr1[9:2]] <= ram_wdata1;
  always @(posedge clk) if (ram_w3) mem3[ram_addr3[9:2]] <= ram_wdata3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;

    // 1: reset state
    cyc(); cyc();
    chk("rst_i_ack",     {31'b0, i_ack1}, 32'h0);
    chk("rst_d_ack",     {31'b0, d_ack1}, 32'h0);
    chk("rst_i_rdata",   i_rdata1,        32'h0);
    chk("rst_d_rdata",   d_rdata1,        32'h0);
    chk("rst_ram_addr",  ram_addr1,       32'h0);
    chk("rst_ram_wdata", ram_wdata1,      32'h0);
    chk("rst_ram_r",     {31'b0, ram_r1}, 32'h0);
    chk("rst_ram_w",     {31'b0, ram_w1}, 32'h0);
    chk("rst_busy",      {31'b0, busy1},  32'h0);
    rst1 = 1'b0;

    // 2: store 0xDEADBEEF to 0x20
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    cyc();
    chk("st_acc_ram_w",     {31'b0, ram_w1}, 32'h1);
    chk("st_acc_ram_r",     {31'b0, ram_r1}, 32'h0);
    chk("st_acc_ram_addr",  ram_addr1,       32'h20);
    chk("st_acc_ram_wdata", ram_wdata1,      32'hDEADBEEF);
    chk("st_acc_busy",      {31'b0, busy1},  32'h1);
    chk("st_acc_d_ack",     {31'b0, d_ack1}, 32'h0);
    cyc();
    chk("st_resp_d_ack",  {31'b0, d_ack1}, 32'h1);
    chk("st_resp_i_ack",  {31'b0, i_ack1}, 32'h0);
    chk("st_resp_ram_w",  {31'b0, ram_w1}, 32'h0);
    chk("st_resp_d_rdata", d_rdata1,       32'h0);
    d_req = 1'b0; d_we = 1'b0;
    cyc();
    chk("st_idle_busy",  {31'b0, busy1},  32'h0);
    chk("st_idle_d_ack", {31'b0, d_ack1}, 32'h0);
    chk("st_mem",        mem1[8],         32'hDEADBEEF);

    // 3: fetch then load of 0x20
    i_req = 1'b1; i_addr = 32'h20;
    cyc();
    chk("ld_i_ram_r",    {31'b0, ram_r1}, 32'h1);
    chk("ld_i_ram_w",    {31'b0, ram_w1}, 32'h0);
    chk("ld_i_ram_addr", ram_addr1,       32'h20);
    cyc();
    chk("ld_i_ack",      {31'b0, i_ack1}, 32'h1);
    chk("ld_i_d_ack",    {31'b0, d_ack1}, 32'h0);
    chk("ld_i_rdata",    i_rdata1,        32'hDEADBEEF);
    chk("ld_i_ram_r_off", {31'b0, ram_r1}, 32'h0);
    i_req = 1'b0;
    cyc();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    cyc();
    chk("ld_d_ram_r", {31'b0, ram_r1}, 32'h1);
    cyc();
    chk("ld_d_ack",   {31'b0, d_ack1}, 32'h1);
    chk("ld_d_rdata", d_rdata1,        32'hDEADBEEF);
    d_req = 1'b0;
    cyc();

    // 4: contention from reset release, acks D,I,D,I three cycles apart
    rst1 = 1'b1;
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    cyc();
    rst1 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("cont_d_ack_%0d", k), {31'b0, d_ack1}, {31'b0, (k == 2 || k == 8)});
      chk($sformatf("cont_i_ack_%0d", k), {31'b0, i_ack1}, {31'b0, (k == 5 || k == 11)});
    end
    chk("cont_d_rdata", d_rdata1, 32'hDEADBEEF);
    chk("cont_i_rdata", i_rdata1, 32'hDEADBEEF);
    i_req = 1'b0; d_req = 1'b0;
    cyc(); cyc(); cyc();
    chk("cont_idle_busy", {31'b0, busy1}, 32'h0);

    // 6: address change during ACCESS is ignored
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    cyc();
    chk("stab_acc_addr", ram_addr1, 32'h20);
    d_addr = 32'h40; d_wdata = 32'h0BADF00D;
    #1;
    chk("stab_acc_addr_after_chg", ram_addr1, 32'h20);
    chk("stab_acc_ram_r",          {31'b0, ram_r1}, 32'h1);
    cyc();
    chk("stab_resp_addr",  ram_addr1, 32'h20);
    chk("stab_resp_ack",   {31'b0, d_ack1}, 32'h1);
    chk("stab_resp_rdata", d_rdata1,  32'hDEADBEEF);
    d_req = 1'b0;
    cyc(); cyc();

    // 5: reset in the 2nd ACCESS cycle, WaitCycles=3
    rst3 = 1'b1;
    cyc(); cyc();
    rst3 = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h12345678;
    cyc();
    chk("rmid_acc1_ram_w", {31'b0, ram_w3}, 32'h1);
    chk("rmid_acc1_busy",  {31'b0, busy3},  32'h1);
    cyc();
    chk("rmid_acc2_ram_w", {31'b0, ram_w3}, 32'h1);
    rst3 = 1'b1;
    cyc();
    chk("rmid_busy",     {31'b0, busy3},  32'h0);
    chk("rmid_ram_r",    {31'b0, ram_r3}, 32'h0);
    chk("rmid_ram_w",    {31'b0, ram_w3}, 32'h0);
    chk("rmid_d_ack",    {31'b0, d_ack3}, 32'h0);
    chk("rmid_ram_addr", ram_addr3,       32'h0);
    rst3 = 1'b0; d_req = 1'b0; d_we = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("rmid_no_d_ack_%0d", k), {31'b0, d_ack3}, 32'h0);
      chk($sformatf("rmid_no_i_ack_%0d", k), {31'b0, i_ack3}, 32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
